// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit types, address geometry, header field
// offsets and router port codes used by the injector and route processor.
package noc_pkg;

   typedef enum logic [1:0] {
      FLIT_BODY      = 2'b00,
      FLIT_HEAD      = 2'b01,
      FLIT_TAIL      = 2'b10,
      FLIT_HEAD_TAIL = 2'b11
   } flit_type_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BODY = 1'b1
   } inj_state_t;

   localparam int ADDR_W  = 8;
   localparam int COORD_W = 4;

   localparam int DEST_LSB = 0;
   localparam int SRC_LSB  = 8;
   localparam int LEN_LSB  = 16;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   function automatic logic [ADDR_W-1:0] make_addr(
      input logic [COORD_W-1:0] y,
      input logic [COORD_W-1:0] x
   );
      return {y, x};
   endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Tracks free slots in the router's local input buffer.
// Ports: clk_i, rst_ni, consume (flit emitted), returned (credit back),
// count (free slots), has_credit (count != 0).
module noc_credit_counter
   import noc_pkg::*;
#(
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             consume,
   input  logic             returned,
   output logic [CNT_W-1:0] count,
   output logic             has_credit
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   // consume is only raised while has_credit is high, so no underflow
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= FULL;
      end else if (consume && !returned) begin
         count <= count - ONE;
      end else if (returned && !consume && count != FULL) begin
         count <= count + ONE;
      end
   end

   assign has_credit = (count != '0);

endmodule

// File: rtl/noc_packet_injector.sv
// Network-interface transmitter: header flit from {dest,src,len}, then
// payload words as body/tail flits, gated by router buffer credits.
// Ports: request (req_*), payload (pld_*), registered flit output
// (flit_valid_o, flit_o = {type, data}), credit_i return, busy_o.
module noc_packet_injector
   import noc_pkg::*;
#(
   parameter int FLIT_DATA_W = 32,
   parameter int BUF_DEPTH   = 4,
   parameter int MAX_LEN     = 15,
   localparam int LW         = $clog2(MAX_LEN + 1),
   localparam int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [ADDR_W-1:0]      router_addr_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [ADDR_W-1:0]      req_dest_i,
   input  logic [LW-1:0]          req_len_i,
   input  logic                   pld_valid_i,
   output logic                   pld_ready_o,
   input  logic [FLIT_DATA_W-1:0] pld_data_i,
   output logic                   flit_valid_o,
   output logic [FLIT_DATA_W+1:0] flit_o,
   input  logic                   credit_i,
   output logic                   busy_o
);

   localparam logic [LW-1:0] LEN_ONE = LW'(1);

   inj_state_t state;
   inj_state_t state_d;

   logic [LW-1:0]          rem_q;
   logic [LW-1:0]          rem_d;
   logic [FLIT_DATA_W+1:0] flit_d;
   logic                   valid_d;
   logic [FLIT_DATA_W-1:0] hdr;

   logic             has_credit;
   logic [CNT_W-1:0] credit_cnt;
   logic             req_hs;
   logic             pld_hs;

   noc_credit_counter #(
      .BUF_DEPTH (BUF_DEPTH),
      .CNT_W     (CNT_W)
   ) u_credit (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .consume    (req_hs || pld_hs),
      .returned   (credit_i),
      .count      (credit_cnt),
      .has_credit (has_credit)
   );

   assign req_ready_o = (state == S_IDLE) && has_credit;
   assign pld_ready_o = (state == S_BODY) && has_credit;
   assign req_hs      = req_valid_i && req_ready_o;
   assign pld_hs      = pld_valid_i && pld_ready_o;
   assign busy_o      = (state != S_IDLE);

   always_comb begin
      hdr = '0;
      hdr[DEST_LSB +: ADDR_W] = req_dest_i;
      hdr[SRC_LSB  +: ADDR_W] = router_addr_i;
      hdr[LEN_LSB  +: LW]     = req_len_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      rem_d   = rem_q;
      valid_d = 1'b0;
      flit_d  = flit_o;
      unique case (state)
         S_IDLE: begin
            if (req_hs) begin
               valid_d = 1'b1;
               rem_d   = req_len_i;
               // a zero-length packet is a single flit; stay ready
               if (req_len_i == '0) begin
                  flit_d = {FLIT_HEAD_TAIL, hdr};
               end else begin
                  flit_d  = {FLIT_HEAD, hdr};
                  state_d = S_BODY;
               end
            end
         end
         S_BODY: begin
            if (pld_hs) begin
               valid_d = 1'b1;
               rem_d   = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) begin
                  flit_d  = {FLIT_TAIL, pld_data_i};
                  state_d = S_IDLE;
               end else begin
                  flit_d = {FLIT_BODY, pld_data_i};
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flit_valid_o <= 1'b0;
         flit_o       <= '0;
         rem_q        <= '0;
      end else begin
         flit_valid_o <= valid_d;
         flit_o       <= flit_d;
         rem_q        <= rem_d;
      end
   end

endmodule
